// File: rtl/thiele_fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches under a credit limit,
// buffers in-order responses with their fetch PCs, and flushes on redirect.
module thiele_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [31:0]                mem_rsp_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr_data,
    output logic [31:0]                instr_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       rsp_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] out_q, out_d;
    logic [31:0]   disc_q, disc_d;
    logic [AW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [AW-1:0] t_wr_q, t_wr_d, t_rd_q, t_rd_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   fdata_q [DEPTH];
    logic [31:0]   fpc_q   [DEPTH];
    logic [31:0]   tag_q   [DEPTH];

    logic          credit_ok;
    logic          req_fire;
    logic          has_pending;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          fifo_push;
    logic          fifo_pop;

    // Credit covers both buffered words and fetches still owed by memory.
    assign credit_ok     = ({1'b0, occ_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
    assign mem_req_valid = !rst && !redirect && credit_ok;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign has_pending   = (out_q != '0) || (disc_q != '0);
    assign rsp_fire      = mem_rsp_valid && has_pending;
    assign rsp_keep      = rsp_fire && (disc_q == '0);
    assign fifo_push     = rsp_keep && !redirect;
    assign fifo_pop      = instr_valid && instr_ready && !redirect;

    assign mem_req_addr  = fetch_pc_q;
    assign instr_valid   = (occ_q != '0);
    assign instr_data    = instr_valid ? fdata_q[f_rd_q] : '0;
    assign instr_pc      = instr_valid ? fpc_q[f_rd_q]   : '0;
    assign occupancy     = occ_q;
    assign rsp_err       = rsp_err_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_q;
        out_d      = out_q;
        disc_d     = disc_q;
        f_wr_d     = f_wr_q;
        f_rd_d     = f_rd_q;
        t_wr_d     = t_wr_q;
        t_rd_d     = t_rd_q;
        rsp_err_d  = rsp_err_q | (mem_rsp_valid && !has_pending);

        if (redirect) begin
            // Everything owed by memory becomes discard; a response landing now is already consumed.
            fetch_pc_d = redirect_pc & ~32'h3;
            occ_d      = '0;
            out_d      = '0;
            disc_d     = disc_q + 32'(out_q) - (rsp_fire ? 32'd1 : 32'd0);
            f_wr_d     = '0;
            f_rd_d     = '0;
            t_wr_d     = '0;
            t_rd_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                t_wr_d     = t_wr_q + AW'(1);
            end
            out_d = out_q + CW'(req_fire) - CW'(rsp_keep);
            if (rsp_fire && (disc_q != '0)) begin
                disc_d = disc_q - 32'd1;
            end
            if (fifo_push) begin
                t_rd_d = t_rd_q + AW'(1);
                f_wr_d = f_wr_q + AW'(1);
            end
            if (fifo_pop) begin
                f_rd_d = f_rd_q + AW'(1);
            end
            occ_d = occ_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            occ_q      <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            f_wr_q     <= '0;
            f_rd_q     <= '0;
            t_wr_q     <= '0;
            t_rd_q     <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            f_wr_q     <= f_wr_d;
            f_rd_q     <= f_rd_d;
            t_wr_q     <= t_wr_d;
            t_rd_q     <= t_rd_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[t_wr_q] <= fetch_pc_q;
        end
        if (fifo_push) begin
            fdata_q[f_wr_q] <= mem_rsp_data;
            fpc_q[f_wr_q]   <= tag_q[t_rd_q];
        end
    end
endmodule

// File: tb/tb_thiele_fetch_queue.sv
// Directed bench for thiele_fetch_queue: a per-cycle vector table plus
// multi-cycle sequences driven through a latency-configurable memory model.
module tb_thiele_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  occupancy;
    logic        rsp_err;

    thiele_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
        .occupancy(occupancy), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) assert (occupancy <= 3'd4) else $error("FAIL no_overflow occupancy=%0d", occupancy);
    end

    int          npass = 0;
    int          ntot  = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          fires = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] first_pc = '0;
    logic [31:0] rq[$];
    int          rdue[$];

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        mrdy;
        logic        rv;
        logic [31:0] rdat;
        logic        ird;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_idat;
        logic [2:0]  e_occ;
        logic        e_err;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; instr_ready = 1'b0;
        rq.delete(); rdue.delete();
        @(negedge clk);
        rst = 1'b0;
        fires = 0; delivered = 0; exp_pc = '0;
    endtask

    // One cycle: memory model drives responses, then fires are recorded and deliveries scored.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic mrdy, input logic ird);
        @(negedge clk);
        redirect = rd; redirect_pc = rpc; mem_req_ready = mrdy; instr_ready = ird;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        if (rq.size() > 0 && rdue[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rq[0] ^ 32'hA5A5_0000;
            void'(rq.pop_front());
            void'(rdue.pop_front());
        end
        #1;
        if (mem_req_valid && mem_req_ready) begin
            fires++;
            rq.push_back(mem_req_addr);
            rdue.push_back(cyc + lat);
        end
        if (instr_valid && instr_ready && !redirect) begin
            if (delivered == 0) first_pc = instr_pc;
            chk("deliv_pc", instr_pc, exp_pc);
            chk("deliv_data", instr_data, exp_pc ^ 32'hA5A5_0000);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, mem_req_addr, 32'h0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr_data"}, instr_data, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{0, 0,      0, 0, 0,       0,  1, 32'h0,   0, 32'h0,   32'h0,  3'd0, 0};
        tbl[1]  = '{0, 0,      1, 0, 0,       0,  1, 32'h0,   0, 32'h0,   32'h0,  3'd0, 0};
        tbl[2]  = '{0, 0,      1, 1, 32'h11,  0,  1, 32'h4,   0, 32'h0,   32'h0,  3'd0, 0};
        tbl[3]  = '{0, 0,      0, 0, 0,       0,  1, 32'h8,   1, 32'h0,   32'h11, 3'd1, 0};
        tbl[4]  = '{0, 0,      1, 1, 32'h22,  1,  1, 32'h8,   1, 32'h0,   32'h11, 3'd1, 0};
        tbl[5]  = '{0, 0,      0, 0, 0,       0,  1, 32'hC,   1, 32'h4,   32'h22, 3'd1, 0};
        tbl[6]  = '{1, 32'h203,1, 1, 32'h33,  1,  0, 32'hC,   1, 32'h4,   32'h22, 3'd1, 0};
        tbl[7]  = '{0, 0,      0, 0, 0,       0,  1, 32'h200, 0, 32'h0,   32'h0,  3'd0, 0};
        tbl[8]  = '{0, 0,      1, 0, 0,       0,  1, 32'h200, 0, 32'h0,   32'h0,  3'd0, 0};
        tbl[9]  = '{1, 32'h300,1, 0, 0,       0,  0, 32'h204, 0, 32'h0,   32'h0,  3'd0, 0};
        tbl[10] = '{0, 0,      1, 1, 32'hDEAD,0,  1, 32'h300, 0, 32'h0,   32'h0,  3'd0, 0};
        tbl[11] = '{0, 0,      0, 1, 32'h44,  0,  1, 32'h304, 0, 32'h0,   32'h0,  3'd0, 0};
        tbl[12] = '{0, 0,      0, 1, 32'h55,  0,  1, 32'h304, 1, 32'h300, 32'h44, 3'd1, 0};
        tbl[13] = '{0, 0,      0, 0, 0,       1,  1, 32'h304, 1, 32'h300, 32'h44, 3'd1, 1};
        tbl[14] = '{0, 0,      0, 0, 0,       0,  1, 32'h304, 0, 32'h0,   32'h0,  3'd0, 1};

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Per-cycle vector table
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            redirect = tbl[i].rd; redirect_pc = tbl[i].rpc; mem_req_ready = tbl[i].mrdy;
            mem_rsp_valid = tbl[i].rv; mem_rsp_data = tbl[i].rdat; instr_ready = tbl[i].ird;
            #1;
            chk($sformatf("v%0d_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].e_rv));
            chk($sformatf("v%0d_req_addr", i), mem_req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_iv));
            chk($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
            chk($sformatf("v%0d_instr_data", i), instr_data, tbl[i].e_idat);
            chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(tbl[i].e_err));
        end

        // Streaming at one-cycle memory latency
        apply_reset();
        lat = 1;
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("stream_count_ok", 32'(delivered >= 30), 32'd1);
        chk("stream_rsp_err", 32'(rsp_err), 32'd0);

        // Reset asserted mid-burst takes effect without a clock edge
        #3;
        rst = 1'b1; redirect = 1'b0; mem_req_ready = 1'b0; instr_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        rq.delete(); rdue.delete();
        @(negedge clk);
        rst = 1'b0;

        // Backpressure: credit limit then one pop admits one request
        apply_reset();
        lat = 1;
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("bp_fires", 32'(fires), 32'd4);
        chk("bp_occupancy", 32'(occupancy), 32'd4);
        chk("bp_req_valid", 32'(mem_req_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        fires = 0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("bp_refill_fires", 32'(fires), 32'd1);
        chk("bp_refill_occupancy", 32'(occupancy), 32'd4);

        // Redirect with three slow responses in flight
        apply_reset();
        lat = 5;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        exp_pc = 32'h100; delivered = 0;
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("rdr3_delivered_any", 32'(delivered > 0), 32'd1);
        chk("rdr3_first_pc", first_pc, 32'h100);
        chk("rdr3_rsp_err", 32'(rsp_err), 32'd0);

        // Redirect coinciding with a response and a pop at occupancy 2
        apply_reset();
        lat = 2;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("coin_pre_occupancy", 32'(occupancy), 32'd2);
        step(1'b1, 32'h40, 1'b1, 1'b1);
        #1;
        chk("coin_occupancy", 32'(occupancy), 32'd0);
        chk("coin_instr_valid", 32'(instr_valid), 32'd0);
        exp_pc = 32'h40; delivered = 0;
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("coin_delivered_any", 32'(delivered > 0), 32'd1);
        chk("coin_first_pc", first_pc, 32'h40);

        // Address wrap and low-bit masking of redirect_pc
        lat = 1;
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        exp_pc = 32'hFFFF_FFFC; delivered = 0;
        #1;
        chk("wrap_addr_top", mem_req_addr, 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b1, 1'b1);
        #1;
        chk("wrap_addr_zero", mem_req_addr, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);
        step(1'b1, 32'h103, 1'b1, 1'b1);
        exp_pc = 32'h100; delivered = 0;
        #1;
        chk("mask_addr", mem_req_addr, 32'h100);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("mask_first_pc", first_pc, 32'h100);

        // Unsolicited response sets a sticky error and leaves the FIFO alone
        apply_reset();
        lat = 1;
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        #1;
        chk("err_set", 32'(rsp_err), 32'd1);
        chk("err_occupancy", 32'(occupancy), 32'd2);
        chk("err_head_pc", instr_pc, 32'h0);
        chk("err_head_data", instr_data, 32'hA5A5_0000);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("err_sticky", 32'(rsp_err), 32'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
